// File: rtl/raster_address_generator_pkg.sv
// Shared definitions for the raster address generator: FSM encoding and
// default widths used by the top and the 2-D counter.
package raster_address_generator_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_COL_W  = 8;
    localparam int DEF_ROW_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } gen_state_t;

endpackage

// File: rtl/raster_address_generator_counter2d.sv
// Column/row counter pair walking a cols x rows raster; wraps to (0,0)
// after the last position of the frame.
module raster_counter2d
    import raster_address_generator_pkg::*;
#(
    parameter int COL_W = DEF_COL_W,
    parameter int ROW_W = DEF_ROW_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    input  logic [COL_W-1:0] cols,
    input  logic [ROW_W-1:0] rows,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last_col,
    output logic             last_frame
);

    assign last_col   = (col == cols);
    assign last_frame = last_col && (row == rows);

    // NOTE: sequential state is written with <= only, so every register in
    // this block samples the pre-edge values of its neighbours.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (inc) begin
            if (last_col) begin
                col <= '0;
                row <= last_frame ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/raster_address_generator.sv
// Raster address generator: emits row_base+col for a configurable 2-D frame
// with ready/valid handshake, optional continuous restart and a done pulse.
module raster_address_generator
    import raster_address_generator_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int COL_W  = DEF_COL_W,
    parameter int ROW_W  = DEF_ROW_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [COL_W-1:0]  cfg_cols,
    input  logic [ROW_W-1:0]  cfg_rows,
    input  logic [ADDR_W-1:0] cfg_stride,
    input  logic              cfg_continuous,
    input  logic              ready,
    output logic [ADDR_W-1:0] address,
    output logic              valid,
    output logic              last_col,
    output logic              last_frame,
    output logic              busy,
    output logic              done
);

    gen_state_t state_q, state_d;

    logic [ADDR_W-1:0] base_q;
    logic [COL_W-1:0]  cols_q;
    logic [ROW_W-1:0]  rows_q;
    logic [ADDR_W-1:0] stride_q;
    logic              cont_q;
    logic [ADDR_W-1:0] row_base;

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              cnt_last_col;
    logic              cnt_last_frame;
    logic              load;
    logic              transfer;

    raster_counter2d #(
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_counter (
        .clock      (clock),
        .reset      (reset),
        .inc        (transfer),
        .clear      (load),
        .cols       (cols_q),
        .rows       (rows_q),
        .col        (col),
        .row        (row),
        .last_col   (cnt_last_col),
        .last_frame (cnt_last_frame)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    load    = 1'b1;
                end
            end
            ST_RUN: begin
                if (ready && cnt_last_frame && !cont_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign valid    = (state_q == ST_RUN);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign transfer = valid && ready;

    assign address    = row_base + ADDR_W'(col);
    assign last_col   = valid && cnt_last_col;
    assign last_frame = valid && cnt_last_frame;

    // Configuration is sampled once per start; the frame-end reload of
    // row_base is harmless in one-shot mode because DONE ignores it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            base_q   <= '0;
            cols_q   <= '0;
            rows_q   <= '0;
            stride_q <= '0;
            cont_q   <= 1'b0;
            row_base <= '0;
        end else if (load) begin
            base_q   <= cfg_base;
            cols_q   <= cfg_cols;
            rows_q   <= cfg_rows;
            stride_q <= cfg_stride;
            cont_q   <= cfg_continuous;
            row_base <= cfg_base;
        end else if (transfer) begin
            if (cnt_last_frame) begin
                row_base <= base_q;
            end else if (cnt_last_col) begin
                row_base <= row_base + stride_q;
            end
        end
    end

endmodule

// File: tb/tb_raster_address_generator.sv
// Bench for raster_address_generator: queue-based frame model checked every
// cycle plus literal expectations for the directed scenarios.
module tb_raster_address_generator;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] cfg_base;
    logic [7:0]  cfg_cols;
    logic [7:0]  cfg_rows;
    logic [15:0] cfg_stride;
    logic        cfg_continuous;
    logic        ready;
    logic [15:0] address;
    logic        valid;
    logic        last_col;
    logic        last_frame;
    logic        busy;
    logic        done;

    raster_address_generator #(
        .ADDR_W (16),
        .COL_W  (8),
        .ROW_W  (8)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .cfg_base       (cfg_base),
        .cfg_cols       (cfg_cols),
        .cfg_rows       (cfg_rows),
        .cfg_stride     (cfg_stride),
        .cfg_continuous (cfg_continuous),
        .ready          (ready),
        .address        (address),
        .valid          (valid),
        .last_col       (last_col),
        .last_frame     (last_frame),
        .busy           (busy),
        .done           (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        logic        lc;
        logic        lf;
    } beat_t;

    // Model state: expected beats of the current frame and the frame config.
    beat_t       exp_q[$];
    logic        done_due;
    logic [15:0] m_base;
    logic [15:0] m_stride;
    int          m_cols;
    int          m_rows;
    logic        m_cont;

    // Observations of accepted beats for the literal checks.
    logic [15:0] xfer_log[$];
    logic        lc_log[$];
    logic        lf_log[$];
    int          done_count = 0;
    logic [15:0] exp_list[$];

    function automatic void build_frame();
        beat_t b;
        for (int r = 0; r <= m_rows; r++) begin
            for (int c = 0; c <= m_cols; c++) begin
                b.addr = m_base + 16'(r * int'(m_stride)) + 16'(c);
                b.lc   = (c == m_cols);
                b.lf   = (c == m_cols) && (r == m_rows);
                exp_q.push_back(b);
            end
        end
    endfunction

    // Compare process: outputs now vs model, then advance the model using
    // the inputs the DUT will sample at the coming rising edge.
    always @(negedge clock) begin
        if (reset) begin
            check("rst_valid", valid, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_done", done, 1'b0);
            check("rst_addr", address, 16'h0);
            check("rst_lc", last_col, 1'b0);
            check("rst_lf", last_frame, 1'b0);
            exp_q.delete();
            done_due = 1'b0;
        end else if (exp_q.size() > 0) begin
            check("run_valid", valid, 1'b1);
            check("run_busy", busy, 1'b1);
            check("run_done", done, 1'b0);
            check("run_addr", address, exp_q[0].addr);
            check("run_lc", last_col, exp_q[0].lc);
            check("run_lf", last_frame, exp_q[0].lf);
            if (ready) begin
                xfer_log.push_back(address);
                lc_log.push_back(last_col);
                lf_log.push_back(last_frame);
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    if (m_cont) build_frame();
                    else done_due = 1'b1;
                end
            end
        end else if (done_due) begin
            check("done_valid", valid, 1'b0);
            check("done_busy", busy, 1'b1);
            check("done_pulse", done, 1'b1);
            done_due = 1'b0;
        end else begin
            check("idle_valid", valid, 1'b0);
            check("idle_busy", busy, 1'b0);
            check("idle_done", done, 1'b0);
            check("idle_lc", last_col, 1'b0);
            check("idle_lf", last_frame, 1'b0);
            if (start) begin
                m_base   = cfg_base;
                m_stride = cfg_stride;
                m_cols   = int'(cfg_cols);
                m_rows   = int'(cfg_rows);
                m_cont   = cfg_continuous;
                build_frame();
            end
        end
        if (!reset && done) done_count++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_logs();
        xfer_log.delete();
        lc_log.delete();
        lf_log.delete();
    endtask

    task automatic start_frame(input logic [15:0] base, input logic [7:0] cols,
                               input logic [7:0] rows, input logic [15:0] stride,
                               input logic cont);
        cfg_base       = base;
        cfg_cols       = cols;
        cfg_rows       = rows;
        cfg_stride     = stride;
        cfg_continuous = cont;
        start          = 1'b1;
        tick();
        start          = 1'b0;
        // Scramble cfg to show the latched copy is what drives the frame.
        cfg_base       = 16'hDEAD;
        cfg_cols       = 8'h05;
        cfg_rows       = 8'h03;
        cfg_stride     = 16'h0777;
        cfg_continuous = 1'b0;
    endtask

    task automatic wait_done(input string name, input bit bp);
        int prev = done_count;
        int n = 0;
        while (done_count == prev && n < 300) begin
            ready = bp ? ((n % 4 == 0) || (n % 4 == 3)) : 1'b1;
            tick();
            n++;
        end
        ready = 1'b1;
        check(name, done_count != prev, 1'b1);
        tick();
    endtask

    task automatic check_log(input string name);
        check({name, "_len"}, xfer_log.size(), exp_list.size());
        foreach (exp_list[i]) begin
            if (i < xfer_log.size()) check({name, "_addr"}, xfer_log[i], exp_list[i]);
        end
    endtask

    initial begin
        int d0;
        int n;
        reset = 1'b1;
        start = 1'b0;
        ready = 1'b1;
        cfg_base = '0; cfg_cols = '0; cfg_rows = '0; cfg_stride = '0; cfg_continuous = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Basic raster
        clear_logs();
        start_frame(16'h0100, 8'd2, 8'd1, 16'h0010, 1'b0);
        wait_done("basic_done", 1'b0);
        exp_list = '{16'h0100, 16'h0101, 16'h0102, 16'h0110, 16'h0111, 16'h0112};
        check_log("basic");
        if (lc_log.size() == 6) begin
            check("basic_lc3", lc_log[2], 1'b1);
            check("basic_lc4", lc_log[3], 1'b0);
            check("basic_lc6", lc_log[5], 1'b1);
            check("basic_lf3", lf_log[2], 1'b0);
            check("basic_lf6", lf_log[5], 1'b1);
        end
        check("basic_idle", busy, 1'b0);

        // Backpressure, same config
        clear_logs();
        start_frame(16'h0100, 8'd2, 8'd1, 16'h0010, 1'b0);
        wait_done("bp_done", 1'b1);
        check_log("bp");

        // Wrap around 2^16
        clear_logs();
        start_frame(16'hFFFE, 8'd3, 8'd0, 16'h0100, 1'b0);
        wait_done("wrap_done", 1'b0);
        exp_list = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        check_log("wrap");

        // Single address
        clear_logs();
        start_frame(16'h0042, 8'd0, 8'd0, 16'h0000, 1'b0);
        wait_done("single_done", 1'b0);
        exp_list = '{16'h0042};
        check_log("single");
        if (lc_log.size() == 1) begin
            check("single_lc", lc_log[0], 1'b1);
            check("single_lf", lf_log[0], 1'b1);
        end
        check("single_idle", busy, 1'b0);

        // Continuous mode, with start pulses that must be ignored
        clear_logs();
        d0 = done_count;
        start_frame(16'h0000, 8'd1, 8'd0, 16'h0000, 1'b1);
        for (int i = 0; i < 9; i++) tick();
        cfg_base = 16'h4000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("cont_no_done", done_count, d0);
        check("cont_valid", valid, 1'b1);
        check("cont_len", xfer_log.size() >= 19, 1'b1);
        foreach (xfer_log[i]) check("cont_addr", xfer_log[i], 16'(i % 2));
        reset = 1'b1;
        #1;
        check("cont_rst_valid", valid, 1'b0);
        tick();
        reset = 1'b0;
        tick();

        // Reset mid-frame after the second transfer
        clear_logs();
        d0 = done_count;
        start_frame(16'h0100, 8'd2, 8'd1, 16'h0010, 1'b0);
        n = 0;
        while (xfer_log.size() < 2 && n < 50) begin
            tick();
            n++;
        end
        check("midrst_two_xfers", xfer_log.size(), 2);
        reset = 1'b1;
        #1;
        check("midrst_valid", valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_addr", address, 16'h0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("midrst_no_done", done_count, d0);
        clear_logs();
        start_frame(16'h0300, 8'd1, 8'd0, 16'h0000, 1'b0);
        wait_done("midrst_restart_done", 1'b0);
        exp_list = '{16'h0300, 16'h0301};
        check_log("midrst_restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/raster_address_generator.md
RASTER_ADDRESS_GENERATOR -- requirements
Module: raster_address_generator

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, 16, address width in bits
- COL_W, 8, column-count width
- ROW_W, 8, row-count width
REQ-002 Ports SHALL be:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a frame; sampled in IDLE only
- cfg_base  in  ADDR_W  first address of frame
- cfg_cols  in  COL_W  columns per row minus 1 (0 = 1 column)
- cfg_rows  in  ROW_W  rows per frame minus 1
- cfg_stride  in  ADDR_W  address distance between row starts
- cfg_continuous  in  1  1 = restart frame automatically after last address
- ready  in  1  consumer accepts current address
- address  out  ADDR_W  current address
- valid  out  1  address is valid
- last_col  out  1  current address is last of its row
- last_frame  out  1  current address is last of frame
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after last address of a non-continuous frame is accepted

Function
REQ-003 The FSM SHALL have states IDLE, RUN, DONE; reset enters IDLE.
REQ-004 IDLE: valid=0, busy=0; when start=1, the block SHALL latch all cfg_* inputs, load col=0, row=0, row_base=cfg_base, and enter RUN next cycle.
REQ-005 cfg_* changes SHALL have no effect until the next latch (start in IDLE, or auto-restart).
REQ-006 RUN: valid=1, busy=1, address=row_base+col (modulo 2^ADDR_W); first valid address appears the cycle after start (latency 1).
REQ-007 A transfer SHALL occur only on a cycle with valid=1 and ready=1; with ready=0, address, last_col, last_frame SHALL hold stable.
REQ-008 On transfer with col<cols: col SHALL increment by 1.
REQ-009 On transfer with col==cols and row<rows: col SHALL become 0, row increment, row_base SHALL become row_base+stride (modulo 2^ADDR_W).
REQ-010 On transfer with col==cols and row==rows: if continuous latch=1, col/row SHALL clear, row_base SHALL reload the latched base, staying in RUN with no bubble; else enter DONE.
REQ-011 last_col SHALL equal (col==cols) while valid; last_frame SHALL equal (col==cols && row==rows) while valid; both 0 otherwise.
REQ-012 DONE: valid=0, busy=1, done=1 for exactly one cycle, then IDLE.
REQ-013 start asserted in RUN or DONE SHALL be ignored.
REQ-014 Continuous mode SHALL be exited only by reset.
REQ-015 cols=0 and rows=0 SHALL produce a one-address frame with last_col=last_frame=1.
REQ-016 Arithmetic overflow of row_base or address SHALL wrap silently modulo 2^ADDR_W.

Reset
REQ-017 While reset=1, asynchronously: state=IDLE, address=0, valid=0, last_col=0, last_frame=0, busy=0, done=0, col=0, row=0, row_base=0, latched config=0.
REQ-018 Reset asserted mid-frame SHALL abort it without a done pulse; the first start after release SHALL begin a fresh frame.

Structure
REQ-019 The FSM state encoding and default parameter values SHALL reside in the shared address-generator package.
REQ-020 The col/row counter pair SHALL be one sub-module, raster_counter2d, exposing inc, clear, col, row, last_col, last_frame.

Verification
REQ-021 Basic raster: base=0x0100, cols=2, rows=1, stride=0x0010, ready=1, start pulse -> addresses 0x0100,0x0101,0x0102,0x0110,0x0111,0x0112 on consecutive cycles; last_col on 3rd/6th; last_frame on 6th; done pulse next cycle.
REQ-022 Backpressure: same config, ready toggled 1,0,0,1... -> every address held stable while ready=0, same sequence, no skip or repeat.
REQ-023 Continuous: base=0, cols=1, rows=0, continuous=1 -> 0,1,0,1,... with no idle cycle and no done; start ignored throughout.
REQ-024 Wrap: ADDR_W=16, base=0xFFFE, cols=3, rows=0 -> 0xFFFE,0xFFFF,0x0000,0x0001.
REQ-025 Reset mid-frame: reset asserted after 2nd transfer -> valid, busy, address go to 0 immediately; no done; new start restarts at cfg_base.
REQ-026 Single address: cols=0, rows=0 -> one valid cycle with last_col=last_frame=1, then done pulse, then IDLE.
